// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// States, port-select encoding and the read data returned on a watchdog expiry.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      ACK  = 2'd2
   } state_e;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_e;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   // Round-robin helper: the master that gets priority after p is granted.
   function automatic port_sel_e other_port(input port_sel_e p);
      port_sel_e r;
      if (p == PORT_A) begin
         r = PORT_B;
      end else begin
         r = PORT_A;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Clearable cycle counter for the bus arbiter watchdog.
// o_expired is high during the LIMIT-th enabled cycle after a clear, so the
// owner can leave its wait state on that edge.
module bus_arbiter_watchdog
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 1024
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins, otherwise count enabled cycles and stop at LAST.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = {CW{1'b0}};
      end else if (i_enable && (count_q != LAST)) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_q <= {CW{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expired = i_enable && (count_q == LAST);

endmodule

// File: rtl/bus_arbiter_2.sv
// Two-master round-robin arbiter between the write buffer (port A) and the
// instruction-fetch port (port B) onto one memory bus, one transaction at a time.
// All bus outputs and ready flags are registers; each port's read data is held
// until that port's next read completes.
// Optional watchdog: define BUS_ARBITER_TIMEOUT_EN to abort a bus wait after
// TIMEOUT_CYCLES cycles, returning 32'hDEAD_BEEF and setting sticky o_timeout.
module bus_arbiter_2
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_a_rw,
   input  logic                     i_a_request,
   output logic                     o_a_ready,
   input  logic [ADDRESS_WIDTH-1:0] i_a_address,
   output logic [31:0]              o_a_rdata,
   input  logic [31:0]              i_a_wdata,
   input  logic [3:0]               i_a_wmask,
   input  logic                     i_b_rw,
   input  logic                     i_b_request,
   output logic                     o_b_ready,
   input  logic [ADDRESS_WIDTH-1:0] i_b_address,
   output logic [31:0]              o_b_rdata,
   input  logic [31:0]              i_b_wdata,
   input  logic [3:0]               i_b_wmask,
   output logic                     o_bus_rw,
   output logic                     o_bus_request,
   input  logic                     i_bus_ready,
   output logic [ADDRESS_WIDTH-1:0] o_bus_address,
   input  logic [31:0]              i_bus_rdata,
   output logic [31:0]              o_bus_wdata,
   output logic [3:0]               o_bus_wmask,
   output logic                     o_timeout
);

   state_e                   state_q, state_d;
   port_sel_e                prio_q, prio_d;
   port_sel_e                grant_q, grant_d;
   logic                     rw_q, rw_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic [3:0]               wmask_q, wmask_d;
   logic [31:0]              a_rdata_q, a_rdata_d;
   logic [31:0]              b_rdata_q, b_rdata_d;
   logic                     bus_req_q, bus_req_d;
   logic                     a_ready_q, a_ready_d;
   logic                     b_ready_q, b_ready_d;
   logic                     timeout_q, timeout_d;

   port_sel_e                sel_s;
   logic                     granted_req_s;
   logic                     wd_expired_s;

`ifdef BUS_ARBITER_TIMEOUT_EN
   logic wd_clear_s;
   logic wd_enable_s;

   // The counter is held clear while idle, so it restarts on every entry to BUS.
   assign wd_clear_s  = (state_q == IDLE);
   assign wd_enable_s = (state_q == BUS);

   bus_arbiter_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clock  (i_clock),
      .i_reset_n(i_reset_n),
      .i_clear  (wd_clear_s),
      .i_enable (wd_enable_s),
      .o_expired(wd_expired_s)
   );
`else
   assign wd_expired_s = 1'b0;
`endif

   // Arbitration choice and the request level of the master currently granted.
   always_comb begin
      if (i_a_request && i_b_request) begin
         sel_s = prio_q;
      end else if (i_a_request) begin
         sel_s = PORT_A;
      end else begin
         sel_s = PORT_B;
      end
      if (grant_q == PORT_A) begin
         granted_req_s = i_a_request;
      end else begin
         granted_req_s = i_b_request;
      end
   end

   // Next-state and next-output logic of the IDLE -> BUS -> ACK sequence.
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      grant_d   = grant_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      bus_req_d = bus_req_q;
      a_ready_d = a_ready_q;
      b_ready_d = b_ready_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            a_ready_d = 1'b0;
            b_ready_d = 1'b0;
            if (i_a_request || i_b_request) begin
               grant_d   = sel_s;
               prio_d    = other_port(sel_s);
               bus_req_d = 1'b1;
               state_d   = BUS;
               if (sel_s == PORT_A) begin
                  rw_d    = i_a_rw;
                  addr_d  = i_a_address;
                  wdata_d = i_a_wdata;
                  wmask_d = i_a_wmask;
               end else begin
                  rw_d    = i_b_rw;
                  addr_d  = i_b_address;
                  wdata_d = i_b_wdata;
                  wmask_d = i_b_wmask;
               end
            end else begin
               bus_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         BUS: begin
            if (i_bus_ready || wd_expired_s) begin
               // Ready is only raised if the master is still asking; a master
               // that let go mid-transaction gets a silent ACK pass instead.
               bus_req_d = 1'b0;
               state_d   = ACK;
               if (!i_bus_ready) begin
                  timeout_d = 1'b1;
               end else begin
                  timeout_d = timeout_q;
               end
               if (grant_q == PORT_A) begin
                  a_ready_d = granted_req_s;
                  if (!i_bus_ready) begin
                     a_rdata_d = TIMEOUT_RDATA;
                  end else if (!rw_q) begin
                     a_rdata_d = i_bus_rdata;
                  end else begin
                     a_rdata_d = a_rdata_q;
                  end
               end else begin
                  b_ready_d = granted_req_s;
                  if (!i_bus_ready) begin
                     b_rdata_d = TIMEOUT_RDATA;
                  end else if (!rw_q) begin
                     b_rdata_d = i_bus_rdata;
                  end else begin
                     b_rdata_d = b_rdata_q;
                  end
               end
            end else begin
               bus_req_d = 1'b1;
               state_d   = BUS;
            end
         end
         ACK: begin
            // Wait for both the master and the slave to let go, so a slave
            // holding ready is never taken as the next completion.
            if (!granted_req_s && !i_bus_ready) begin
               a_ready_d = 1'b0;
               b_ready_d = 1'b0;
               state_d   = IDLE;
            end else begin
               a_ready_d = a_ready_q && granted_req_s;
               b_ready_d = b_ready_q && granted_req_s;
               state_d   = ACK;
            end
         end
         default: begin
            bus_req_d = 1'b0;
            a_ready_d = 1'b0;
            b_ready_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   // State, latched transaction fields and all registered outputs.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         prio_q    <= PORT_A;
         grant_q   <= PORT_A;
         rw_q      <= 1'b0;
         addr_q    <= {ADDRESS_WIDTH{1'b0}};
         wdata_q   <= 32'h0000_0000;
         wmask_q   <= 4'b0000;
         a_rdata_q <= 32'h0000_0000;
         b_rdata_q <= 32'h0000_0000;
         bus_req_q <= 1'b0;
         a_ready_q <= 1'b0;
         b_ready_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         grant_q   <= grant_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         bus_req_q <= bus_req_d;
         a_ready_q <= a_ready_d;
         b_ready_q <= b_ready_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_bus_request = bus_req_q;
   assign o_bus_rw      = rw_q;
   assign o_bus_address = addr_q;
   assign o_bus_wdata   = wdata_q;
   assign o_bus_wmask   = wmask_q;
   assign o_a_ready     = a_ready_q;
   assign o_b_ready     = b_ready_q;
   assign o_a_rdata     = a_rdata_q;
   assign o_b_rdata     = b_rdata_q;
   assign o_timeout     = timeout_q;

endmodule
